comm_frame_tx: RTL
==================

// Module: comm_frame_tx
// PURPOSE
//  Fills the CommunicationSender stub. Takes one game message (ball, miss, new-game, new-game-ack)
//  from gameStateModule via send_new_message/message_sent. Packs it into a 4-byte frame
//  (3 payload bytes + XOR checksum) and shifts it out UART 8N1 on uart_txd to the opponent board.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); must be >= 2
// PORTS
//  clock                    in   1  system clock (CLOCK_50)
//  reset                    in   1  synchronous, active-high
//  send_new_message         in   1  request; fields below sampled on the accept cycle
//  ball_message_tx          in   1  message type strobe: ball
//  ball_y_tx                in   9  ball row
//  velocity_x_tx            in   4  |vel_x|, always toward receiver
//  velocity_y_tx            in   4  |vel_y|
//  sign_y_tx                in   1  sign of vel_y
//  miss_message_tx          in   1  message type strobe: miss
//  my_score_tx              in   5  sender's score
//  your_score_tx            in   5  receiver's score
//  you_should_serve_tx      in   1  receiver serves next
//  new_game_message_tx      in   1  message type strobe: new game
//  you_serve_first_tx       in   1  receiver serves first
//  new_game_ack_message_tx  in   1  message type strobe: new-game ack
//  tx_ready                 out  1  idle, next request will be accepted
//  message_sent             out  1  1-cycle pulse: final stop bit completed
//  uart_txd                 out  1  serial line, registered, idles high
// BEHAVIOUR
//  Reset: tx_ready=1, message_sent=0, uart_txd=1, state IDLE, all counters 0.
//  Accept: when IDLE and send_new_message=1 and at least one type strobe=1. Frame latched, tx_ready->0.
//   Request with no strobe: ignored. Request while busy: ignored, never queued.
//  Multiple strobes: priority new_game > new_game_ack > miss > ball.
//  Frame[23:0] = {type[1:0], payload[21:0]}; unused payload bits are 0.
//   ball 2'b00: [21:13] ball_y, [12:9] vel_x, [8:5] vel_y, [4] sign_y
//   miss 2'b01: [21:17] my_score, [16:12] your_score, [11] you_should_serve
//   new_game 2'b10: [21] you_serve_first
//   ack 2'b11: no payload
//  Byte order: B0=F[23:16], B1=F[15:8], B2=F[7:0], B3=B0^B1^B2.
//  Each byte: start bit 0, 8 data bits LSB first, stop bit 1. Every bit lasts exactly CLKS_PER_BIT cycles.
//   No idle gap between bytes.
//  States: IDLE -> START -> DATA(x8) -> STOP -> (byte_idx<3 ? START : DONE) -> IDLE.
//   DONE lasts 1 cycle and drives message_sent=1. tx_ready returns to 1 on the cycle after DONE.
//  Timing: accept on edge T. uart_txd=0 from T+1. Frame occupies 40*CLKS_PER_BIT cycles.
//   message_sent is high in cycle T+40*CLKS_PER_BIT+1.
//  Bit counter is 0..CLKS_PER_BIT-1 and wraps. Byte index is 2 bits.
//   Checksum is computed at accept, not on the fly.
//  Reset mid-frame: uart_txd=1 on the next edge; frame aborted; no message_sent.
//  Input fields may change after accept without effect.
// STRUCTURE
//  pong_comm_pkg: msg_type_t enum (MSG_BALL, MSG_MISS, MSG_NEW_GAME, MSG_ACK), frame bit-position
//   localparams, FRAME_BYTES=4, CLKS_PER_BIT_50M=434. Shared with CommunicationReceiver.
//  Sub-module uart_tx_byte: byte serializer (start, data[7:0] -> busy, done, txd).
//   comm_frame_tx owns frame packing, checksum and byte sequencing.
// TESTING (CLKS_PER_BIT=4, sample uart_txd mid-bit)
//  Ball y=0x1A5, vx=3, vy=2, sign=1 -> bytes 34 A6 50 C2; message_sent at T+161.
//  Miss my=3, your=7, serve=1 -> 46 78 00 3E; tx_ready low T+1..T+161, high T+162.
//  new_game + ball strobes together, serve_first=1 -> new-game frame A0 00 00 A0 only.
//  Ack, then second send_new_message at T+50 -> C0 00 00 C0 once; second request ignored, one message_sent.
//  reset at T+70 mid-ball frame -> uart_txd=1 from T+71; no message_sent; tx_ready=1; next request sends cleanly.
//  send_new_message with no strobe -> uart_txd stays 1; tx_ready stays 1 for 200 cycles.

Source files
------------

// File: rtl/pong_comm_pkg.sv
// Shared definitions for the pong board-to-board link: message types, frame layout and
// helpers used by both the sender and the receiver.
package pong_comm_pkg;

  typedef enum logic [1:0] {
    MSG_BALL     = 2'b00,
    MSG_MISS     = 2'b01,
    MSG_NEW_GAME = 2'b10,
    MSG_ACK      = 2'b11
  } msg_type_t;

  localparam int unsigned FRAME_BYTES      = 4;
  localparam int unsigned CLKS_PER_BIT_50M = 434;

  localparam int unsigned FRAME_W        = 24;
  localparam int unsigned PAYLOAD_W      = 22;

  // Payload bit positions, MSB of each field.
  localparam int unsigned BALL_Y_MSB     = 21;
  localparam int unsigned BALL_VX_MSB    = 12;
  localparam int unsigned BALL_VY_MSB    = 8;
  localparam int unsigned BALL_SIGN_BIT  = 4;
  localparam int unsigned MISS_MY_MSB    = 21;
  localparam int unsigned MISS_YOUR_MSB  = 16;
  localparam int unsigned MISS_SERVE_BIT = 11;
  localparam int unsigned NG_SERVE_BIT   = 21;

  function automatic logic [7:0] frame_checksum(input logic [FRAME_W-1:0] frame);
    return frame[23:16] ^ frame[15:8] ^ frame[7:0];
  endfunction

  // Wire order: B0 = frame MSB byte, B3 = checksum.
  function automatic logic [7:0] frame_byte(input logic [FRAME_W-1:0] frame,
                                            input logic [7:0]         chk,
                                            input logic [1:0]         idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = frame[23:16];
      2'd1:    b = frame[15:8];
      2'd2:    b = frame[7:0];
      default: b = chk;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer. A start accepted on the final stop-bit cycle chains the next
// byte with no idle gap.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done,
  output logic       txd
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            bit_end;

  assign bit_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) begin
          state_d = StStart;
          shift_d = data;
          txd_d   = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          bit_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            state_d = StStop;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          done = 1'b1;
          if (start) begin
            state_d = StStart;
            shift_d = data;
            txd_d   = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign txd  = txd_q;

endmodule

// File: rtl/comm_frame_tx.sv
// Game-message sender: packs one message into a 3-byte frame plus XOR checksum and
// sequences the four bytes back-to-back through the UART serializer.
module comm_frame_tx
  import pong_comm_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_50M
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_new_message,
  input  logic       ball_message_tx,
  input  logic [8:0] ball_y_tx,
  input  logic [3:0] velocity_x_tx,
  input  logic [3:0] velocity_y_tx,
  input  logic       sign_y_tx,
  input  logic       miss_message_tx,
  input  logic [4:0] my_score_tx,
  input  logic [4:0] your_score_tx,
  input  logic       you_should_serve_tx,
  input  logic       new_game_message_tx,
  input  logic       you_serve_first_tx,
  input  logic       new_game_ack_message_tx,
  output logic       tx_ready,
  output logic       message_sent,
  output logic       uart_txd
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [7:0]           chk_q, chk_d;
  logic [1:0]           idx_q, idx_d;

  msg_type_t            new_type;
  logic [PAYLOAD_W-1:0] new_payload;
  logic [FRAME_W-1:0]   new_frame;
  logic                 any_strobe;

  logic                 tx_start, tx_busy, tx_done;
  logic [7:0]           tx_data;

  assign any_strobe = ball_message_tx | miss_message_tx | new_game_message_tx |
                      new_game_ack_message_tx;

  always_comb begin
    new_type    = MSG_BALL;
    new_payload = '0;
    if (new_game_message_tx) begin
      new_type                  = MSG_NEW_GAME;
      new_payload[NG_SERVE_BIT] = you_serve_first_tx;
    end else if (new_game_ack_message_tx) begin
      new_type = MSG_ACK;
    end else if (miss_message_tx) begin
      new_type                        = MSG_MISS;
      new_payload[MISS_MY_MSB -: 5]   = my_score_tx;
      new_payload[MISS_YOUR_MSB -: 5] = your_score_tx;
      new_payload[MISS_SERVE_BIT]     = you_should_serve_tx;
    end else begin
      new_payload[BALL_Y_MSB -: 9]  = ball_y_tx;
      new_payload[BALL_VX_MSB -: 4] = velocity_x_tx;
      new_payload[BALL_VY_MSB -: 4] = velocity_y_tx;
      new_payload[BALL_SIGN_BIT]    = sign_y_tx;
    end
  end

  assign new_frame = {new_type, new_payload};

  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    chk_d    = chk_q;
    idx_d    = idx_q;
    tx_start = 1'b0;
    tx_data  = frame_byte(frame_q, chk_q, idx_q);
    unique case (state_q)
      StIdle: begin
        // First byte comes straight from the inputs so the start bit begins on the accept edge.
        if (send_new_message && any_strobe) begin
          state_d  = StSend;
          frame_d  = new_frame;
          chk_d    = frame_checksum(new_frame);
          idx_d    = 2'd0;
          tx_start = 1'b1;
          tx_data  = new_frame[23:16];
        end
      end
      StSend: begin
        if (tx_done) begin
          if (idx_q == 2'd3) begin
            state_d = StDone;
          end else begin
            idx_d    = idx_q + 2'd1;
            tx_start = 1'b1;
            tx_data  = frame_byte(frame_q, chk_q, idx_q + 2'd1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      frame_q <= '0;
      chk_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      chk_q   <= chk_d;
      idx_q   <= idx_d;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clock(clock),
    .reset(reset),
    .start(tx_start),
    .data (tx_data),
    .busy (tx_busy),
    .done (tx_done),
    .txd  (uart_txd)
  );

  assign tx_ready     = (state_q == StIdle) && !tx_busy;
  assign message_sent = (state_q == StDone);

endmodule
